// File: rtl/bcd_int_if.sv
// Handshake/bus bundle for the BCD-to-binary converter.
//   bcd       : packed BCD operand, four digits [15:12]..[3:0]
//   convert   : start request, level sampled at the rising clock edge
//   num       : last successful 14-bit binary result
//   busy      : conversion in progress
//   conv_done : one-cycle completion pulse (success or error)
//   error     : one-cycle pulse with conv_done when any input digit > 9
// master = requester (drives bcd/convert), slave = converter.
interface bcd_int_if;
    logic [15:0] bcd;
    logic        convert;
    logic [13:0] num;
    logic        busy;
    logic        conv_done;
    logic        error;

    modport master (
        output bcd,
        output convert,
        input  num,
        input  busy,
        input  conv_done,
        input  error
    );

    modport slave (
        input  bcd,
        input  convert,
        output num,
        output busy,
        output conv_done,
        output error
    );
endinterface

// File: rtl/bcd_int.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Four packed BCD digits are converted to a 14-bit unsigned integer in a
// fixed 14 shift/correct steps. An operand containing a digit above 9 is
// rejected in the same cycle with error and conv_done pulses.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_int_if slave modport (bcd, convert, num, busy, conv_done, error)
module bcd_int (
    input  logic      clk,
    input  logic      rst_n,
    bcd_int_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [29:0] work_r;
    logic [29:0] work_s;
    logic [29:0] shifted_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [13:0] num_r;
    logic [13:0] num_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        err_r;
    logic        err_s;

    // True when every nibble of the operand is a legal decimal digit.
    function automatic logic digits_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Undo the decimal carry: any nibble >= 8 after the right shift had a
    // borrowed ten split into 8, so subtract 3 to restore a BCD digit.
    function automatic logic [15:0] dabble_correct(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < 4; k++) begin
            if (v[4*k +: 4] >= 4'd8) begin
                r[4*k +: 4] = v[4*k +: 4] - 4'd3;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Next-state and datapath computation for the two-state controller.
    always_comb begin
        state_s   = state_r;
        work_s    = work_r;
        cnt_s     = cnt_r;
        num_s     = num_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        shifted_s = {1'b0, work_r[29:1]};
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (bus.convert) begin
                    if (digits_valid(bus.bcd)) begin
                        work_s  = {bus.bcd, 14'd0};
                        cnt_s   = 4'd0;
                        busy_s  = 1'b1;
                        state_s = CONV;
                    end else begin
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                // The BCD field LSB moves into bit 13 of the binary field.
                work_s = {dabble_correct(shifted_s[29:14]), shifted_s[13:0]};
                cnt_s  = cnt_r + 4'd1;
                if (cnt_r == 4'd13) begin
                    num_s   = shifted_s[13:0];
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            work_r  <= 30'd0;
            cnt_r   <= 4'd0;
            num_r   <= 14'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            cnt_r   <= cnt_s;
            num_r   <= num_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign bus.num       = num_r;
    assign bus.busy      = busy_r;
    assign bus.conv_done = done_r;
    assign bus.error     = err_r;

endmodule

// File: tb/tb_bcd_int.sv
// Self-checking bench for bcd_int: a cycle-level behavioural model computes
// the decimal value arithmetically and counts down the fixed latency; a
// compare process checks every output on every falling edge, and directed
// scenarios pin the model with literal expectations.
module tb_bcd_int;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_int_if bus ();

    bcd_int dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int          m_rem;
    logic [13:0] m_num;
    logic [13:0] m_pend;
    logic        m_busy;
    logic        m_done;
    logic        m_err;

    function automatic logic valid_bcd(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [13:0] dec_value(input logic [15:0] v);
        int d;
        d = 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
        return d[13:0];
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count down 14 edges after an accepted operand.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_num  <= 14'd0;
            m_pend <= 14'd0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_rem == 0) begin
                if (bus.convert) begin
                    if (valid_bcd(bus.bcd)) begin
                        m_rem  <= 14;
                        m_pend <= dec_value(bus.bcd);
                        m_busy <= 1'b1;
                    end else begin
                        m_done <= 1'b1;
                        m_err  <= 1'b1;
                    end
                end
            end else begin
                if (m_rem == 1) begin
                    m_num  <= m_pend;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
                m_rem <= m_rem - 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("outputs{num,busy,done,err}",
                  {15'd0, bus.num, bus.busy, bus.conv_done, bus.error},
                  {15'd0, m_num, m_busy, m_done, m_err});
        end
    end

    // Issue one convert pulse from idle and wait (bounded) for conv_done.
    task automatic run_conv(input logic [15:0] v, output logic [13:0] r,
                            output logic e, output int nbusy);
        logic got;
        got = 1'b0;
        r = 14'd0;
        e = 1'b0;
        nbusy = 0;
        bus.bcd = v;
        bus.convert = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bus.convert = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.conv_done) begin
                r = bus.num;
                e = bus.error;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("conv_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (!bus.busy && !bus.conv_done) break;
            @(negedge clk);
        end
    endtask

    logic [13:0] r;
    logic        e;
    int          nb;
    logic        seen;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.bcd = 16'h0000;
        bus.convert = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {15'd0, bus.num, bus.busy, bus.conv_done, bus.error}, 32'd0);
        rst_n = 1'b1;

        run_conv(16'h0000, r, e, nb);
        check("zero_num", {18'd0, r}, 32'd0);
        check("zero_err", {31'd0, e}, 32'd0);
        check("zero_busy_cycles", nb, 32'd14);

        run_conv(16'h9999, r, e, nb);
        check("num_9999", {18'd0, r}, 32'h270F);
        run_conv(16'h1234, r, e, nb);
        check("num_1234", {18'd0, r}, 32'h04D2);

        run_conv(16'h0042, r, e, nb);
        check("num_42", {18'd0, r}, 32'd42);
        run_conv(16'h12A4, r, e, nb);
        check("invalid_err", {31'd0, e}, 32'd1);
        check("invalid_num_kept", {18'd0, r}, 32'd42);
        check("invalid_no_busy", nb, 32'd0);
        @(negedge clk);
        check("error_one_cycle", {30'd0, bus.error, bus.conv_done}, 32'd0);

        // Convert pulse during busy must be ignored.
        bus.bcd = 16'h5000;
        bus.convert = 1'b1;
        @(negedge clk);
        bus.convert = 1'b0;
        repeat (4) @(negedge clk);
        bus.bcd = 16'h0001;
        bus.convert = 1'b1;
        @(negedge clk);
        bus.convert = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.conv_done) begin
                seen = 1'b1;
                check("ignore_busy_num", {18'd0, bus.num}, 32'd5000);
                break;
            end
        end
        check("ignore_busy_done_seen", {31'd0, seen}, 32'd1);
        repeat (20) @(negedge clk);
        check("ignore_busy_no_second", {30'd0, bus.busy, bus.conv_done}, 32'd0);

        // Asynchronous reset mid-conversion.
        bus.bcd = 16'h8765;
        bus.convert = 1'b1;
        @(negedge clk);
        bus.convert = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", {15'd0, bus.num, bus.busy, bus.conv_done, bus.error}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.conv_done) seen = 1'b1;
        end
        check("midreset_no_done", {31'd0, seen}, 32'd0);
        run_conv(16'h0007, r, e, nb);
        check("after_reset_num", {18'd0, r}, 32'd7);

        // Back-to-back sweep with convert held high.
        wait_idle();
        for (int n = 0; n < 1000; n++) begin
            bus.bcd = to_bcd(n * 10 + (n % 10));
            bus.convert = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.conv_done) begin
                    seen = 1'b1;
                    check("sweep_num", {18'd0, bus.num}, n * 10 + (n % 10));
                    break;
                end
            end
            if (!seen) check("sweep_timeout", 32'd0, 32'd1);
        end
        bus.convert = 1'b0;
        wait_idle();

        // Random traffic: mostly valid operands, random convert levels.
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            bus.convert = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                bus.bcd = to_bcd(int'($urandom_range(0, 9999)));
            else
                bus.bcd = 16'($urandom);
        end
        bus.convert = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
